// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan controller.
// Imported by mux_scan_ctrl.
package mux_scan_pkg;

  localparam int NUM_CH = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/mux_scan_ctrl.sv
// Steps a 4-to-1 mux through all channels, dwelling DWELL cycles on each,
// and publishes the four captured bits atomically with a done pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       mux_y,
  output logic       sel0,
  output logic       sel1,
  output logic       busy,
  output logic       done,
  output logic [3:0] sample
);

  localparam int CW = $clog2(DWELL) + 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);
  localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_ch;
  logic [2:0]    r_shadow;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_sample;
  logic          w_last;

  assign w_last = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ch     <= '0;
      r_shadow <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sample <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state <= ST_SCAN;
            r_busy  <= 1'b1;
            r_ch    <= '0;
            r_cnt   <= '0;
          end
        end
        ST_SCAN: begin
          if (w_last) begin
            r_cnt <= '0;
            // Last channel publishes all four bits in one write.
            if (r_ch == LAST_CH) begin
              r_sample <= {mux_y, r_shadow};
              r_state  <= ST_DONE;
              r_done   <= 1'b1;
              r_ch     <= '0;
            end else begin
              r_shadow[r_ch] <= mux_y;
              r_ch           <= r_ch + 2'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sel0   = r_ch[0];
  assign sel1   = r_ch[1];
  assign busy   = r_busy;
  assign done   = r_done;
  assign sample = r_sample;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (DWELL=1,2,3) against a
// cycle-count reference model, plus directed scenario checks.
module tb_mux_scan_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]      rst;
  logic [2:0]      start;
  logic [2:0]      y;
  logic [2:0]      sel0;
  logic [2:0]      sel1;
  logic [2:0]      busy;
  logic [2:0]      done;
  logic [2:0][3:0] d;
  logic [2:0][3:0] sample;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_scan_ctrl #(.DWELL(g + 1)) u_dut (
      .clk   (clk),
      .rst   (rst[g]),
      .start (start[g]),
      .mux_y (y[g]),
      .sel0  (sel0[g]),
      .sel1  (sel1[g]),
      .busy  (busy[g]),
      .done  (done[g]),
      .sample(sample[g])
    );
    assign y[g] = d[g][{sel1[g], sel0[g]}];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_t = cycles since the accepted start (1..4D scan, 4D+1 done).
  bit         m_act [3];
  int         m_t   [3];
  logic [3:0] m_smp [3];
  logic [3:0] m_cap [3];

  initial begin
    for (int g = 0; g < 3; g++) begin
      m_act[g] = 0;
      m_t[g]   = 0;
      m_smp[g] = '0;
      m_cap[g] = '0;
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      int dw;
      int ch;
      dw = g + 1;
      ch = (m_t[g] - 1) / dw;
      if (rst[g]) begin
        m_act[g] <= 0;
        m_t[g]   <= 0;
        m_smp[g] <= '0;
        m_cap[g] <= '0;
      end else if (!m_act[g]) begin
        if (start[g]) begin
          m_act[g] <= 1;
          m_t[g]   <= 1;
        end
      end else if (m_t[g] <= 4 * dw) begin
        if (m_t[g] % dw == 0) begin
          if (ch < 3) m_cap[g][ch] <= d[g][ch];
          else m_smp[g] <= {d[g][3], m_cap[g][2:0]};
        end
        m_t[g] <= m_t[g] + 1;
      end else begin
        m_act[g] <= 0;
        m_t[g]   <= 0;
      end
    end
  end

  initial begin
    int dw;
    int es;
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        dw = g + 1;
        es = (m_act[g] && m_t[g] <= 4 * dw) ? (m_t[g] - 1) / dw : 0;
        check($sformatf("m%0d busy", g), 32'(busy[g]), 32'(m_act[g]));
        check($sformatf("m%0d done", g), 32'(done[g]),
              32'(m_act[g] && m_t[g] == 4 * dw + 1));
        check($sformatf("m%0d sel", g), 32'({sel1[g], sel0[g]}), es);
        check($sformatf("m%0d sample", g), 32'(sample[g]), 32'(m_smp[g]));
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    int n;
    int low;
    int cnt;
    rst   = 3'b111;
    start = '0;
    d     = '0;
    repeat (3) step();
    check("rst busy", 32'(busy[0]), 0);
    check("rst done", 32'(done[0]), 0);
    check("rst sel", 32'({sel1[0], sel0[0]}), 0);
    check("rst sample", 32'(sample[0]), 0);
    rst = '0;
    step();

    // DWELL=1, d=1010
    d[0]     = 4'b1010;
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("d1 sel", 32'({sel1[0], sel0[0]}), k);
      check("d1 busy", 32'(busy[0]), 1);
      step();
    end
    check("d1 done", 32'(done[0]), 1);
    check("d1 sample", 32'(sample[0]), 32'h0000_000a);
    step();
    check("d1 idle busy", 32'(busy[0]), 0);
    check("d1 idle done", 32'(done[0]), 0);

    // DWELL=3, d=0110
    d[2]     = 4'b0110;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    n = 1;
    while (!done[2] && n < 40) begin
      step();
      n++;
    end
    check("d3 latency", n, 13);
    check("d3 sample", 32'(sample[2]), 32'h0000_0006);
    step();

    // DWELL=2, channel 1 low only in its first dwell cycle
    d[1]     = 4'b1111;
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    step();
    step();
    d[1] = 4'b1101;
    step();
    d[1] = 4'b1111;
    n = 4;
    while (!done[1] && n < 40) begin
      step();
      n++;
    end
    check("d2 latency", n, 9);
    check("d2 sample bit1", 32'(sample[1][1]), 1);
    check("d2 sample", 32'(sample[1]), 32'h0000_000f);
    step();

    // DWELL=1, start held high
    start[0] = 1'b1;
    n = 0;
    while (!done[0] && n < 20) begin
      step();
      n++;
    end
    check("bb first done", 32'(done[0]), 1);
    n   = 0;
    low = 0;
    do begin
      step();
      n++;
      if (!busy[0]) low++;
    end while (!done[0] && n < 20);
    check("bb period", n, 6);
    check("bb busy low", low, 1);
    start[0] = 1'b0;
    step();
    step();

    // DWELL=2, reset while sel=10
    start[1] = 1'b1;
    step();
    start[1] = 1'b0;
    n = 0;
    while ({sel1[1], sel0[1]} != 2'd2 && n < 20) begin
      step();
      n++;
    end
    check("abort reached sel2", 32'({sel1[1], sel0[1]}), 2);
    rst[1] = 1'b1;
    step();
    rst[1] = 1'b0;
    check("abort sel", 32'({sel1[1], sel0[1]}), 0);
    check("abort busy", 32'(busy[1]), 0);
    check("abort sample", 32'(sample[1]), 0);
    cnt = 0;
    repeat (15) begin
      step();
      if (done[1]) cnt++;
    end
    check("abort no done", cnt, 0);

    // DWELL=3, start pulsed during SCAN and DONE
    cnt      = 0;
    start[2] = 1'b1;
    step();
    start[2] = 1'b0;
    for (int i = 1; i < 30; i++) begin
      if (done[2]) begin
        cnt++;
        start[2] = 1'b1;
      end else begin
        start[2] = (i == 5);
      end
      step();
    end
    start[2] = 1'b0;
    check("ignored starts done count", cnt, 1);
    check("ignored starts idle", 32'(busy[2]), 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom % 4 == 0);
        d[g]     = 4'($urandom);
        rst[g]   = ($urandom % 60 == 0);
      end
      step();
    end
    start = '0;
    rst   = '0;
    repeat (20) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, 1, cycles each select code is held before its channel is sampled; legal range 1..255.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request one full 4-channel scan; sampled only in IDLE.
REQ-005 Port: mux_y  input  1  output y of the downstream-driven 4-to-1 mux (combinational path, same cycle as sel).
REQ-006 Port: sel0  output  1  mux select LSB; channel index = {sel1,sel0}, 0..3 selects d0..d3.
REQ-007 Port: sel1  output  1  mux select MSB.
REQ-008 Port: busy  output  1  high in SCAN and DONE states.
REQ-009 Port: done  output  1  one-cycle pulse; sample valid and updated in the same cycle.
REQ-010 Port: sample  output  4  captured channel values, bit i = mux_y while channel i was selected.

Function
REQ-011 States: IDLE, SCAN, DONE; all outputs registered.
REQ-012 IDLE: sel1:sel0 = 00, busy=0, done=0; start=1 at cycle T -> SCAN at T+1 with channel 0, dwell count 0.
REQ-013 SCAN: channel k occupies cycles T+1+k*DWELL .. T+(k+1)*DWELL; sel1:sel0 = k throughout.
REQ-014 Dwell counter width = ceil(log2(DWELL))+1; increments each SCAN cycle, clears on channel advance.
REQ-015 mux_y captured only on the last dwell cycle of each channel; earlier values ignored.
REQ-016 Channels 0..2 captured into an internal shadow register; channel 3 capture loads sample = {mux_y, shadow[2:0]} atomically.
REQ-017 After channel 3 last dwell cycle -> DONE at T+4*DWELL+1: done=1, sample holds new value, sel returns to 00.
REQ-018 DONE lasts exactly one cycle -> IDLE; start during DONE ignored.
REQ-019 start while in SCAN ignored; no queuing.
REQ-020 sample holds last completed scan until next DONE; never partially updated.
REQ-021 Channel index 3 -> no wrap inside a scan; index returns to 0 only via DONE/IDLE.
REQ-022 Continuous start=1: back-to-back scans with period 4*DWELL+2 cycles.

Reset
REQ-023 rst=1 at any edge -> next cycle state IDLE, sel1:sel0=00, busy=0, done=0, sample=0000, shadow=000, dwell count 0, channel 0.
REQ-024 rst mid-scan aborts without a done pulse; rst overrides simultaneous start.

Structure
REQ-025 Package mux_scan_pkg holds state enum typedef and constant NUM_CH=4.
REQ-026 Single module, no sub-module; bench connects outputs to the team's mux_4to1 fed by a 4-bit pattern d.

Verification
REQ-027 DWELL=1, d=1010, start at cycle 5 -> sel 00,01,10,11 in cycles 6-9; done=1 cycle 10; sample=1010.
REQ-028 DWELL=3, d=0110, start at T -> each sel held 3 cycles; done at T+13; sample=0110.
REQ-029 DWELL=2, d[1]=0 in first dwell cycle of channel 1 then 1 -> sample[1]=1.
REQ-030 DWELL=1, start held high -> done pulses every 6 cycles; busy low exactly 1 cycle between scans.
REQ-031 rst asserted while sel=10 -> next cycle sel=00, busy=0, sample=0000; no done pulse follows.
REQ-032 start pulsed during SCAN and during DONE -> ignored; exactly one done per accepted start.
